// File: rtl/rs_issue_arbiter.sv
// -----------------------------------------------------------------------------
// rs_issue_arbiter
//
// Picks one ready instruction per cycle from the ALU reservation station and
// presents it to the ALU. The pick is registered, so the selected entry appears
// one cycle after it becomes eligible. It is then held stable until the ALU
// accepts it (handshake), the pipeline is flushed, or the entry is dropped
// because its busy bit falls.
//
// Fairness: round-robin. The search starts at ptr. After a successful issue,
// ptr moves to one past the issued entry and wraps from ALU back to 0. Flushes
// and drops leave ptr where it was.
//
// Optional feature: define RS_ISSUE_PERF_EN to enable the saturating
// issueCount/stallCount performance counters. Without it both ports read 0.
//
// Parameters
//   ALU          number of reservation-station entries minus one (N = ALU+1)
//   ROB          ROB tag width minus one (TW = ROB+1)
//
// Ports
//   clk          clock; all state updates on the rising edge
//   reset        synchronous, active-high reset
//   flush        branch redirect; discards any in-flight issue
//   entryBusy    [N]      entry holds a valid instruction
//   entryReady   [N]      entry's operands are all ready
//   entryRob     [N*TW]   ROB tag of entry i at [i*TW +: TW]
//   fuReady      ALU accepts the presented instruction this cycle
//   issueValid   an instruction is being presented
//   issueOneHot  [N]      one-hot select of the presented entry (0 when idle)
//   issueIndex   [IW]     binary index of the presented entry
//   issueRob     [TW]     ROB tag captured when the entry was selected
//   entryRelease [N]      single-cycle pulse freeing the issued entry
//   issueCount   [16]     number of handshakes (saturating, perf build only)
//   stallCount   [16]     cycles presented but not accepted (perf build only)
// -----------------------------------------------------------------------------
module rs_issue_arbiter #(
   parameter  int ALU = 3,
   parameter  int ROB = 2,
   localparam int IW  = (ALU > 0) ? $clog2(ALU + 1) : 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           flush,
   input  logic [ALU:0]                   entryBusy,
   input  logic [ALU:0]                   entryReady,
   input  logic [(ALU+1)*(ROB+1)-1:0]     entryRob,
   input  logic                           fuReady,
   output logic                           issueValid,
   output logic [ALU:0]                   issueOneHot,
   output logic [IW-1:0]                  issueIndex,
   output logic [ROB:0]                   issueRob,
   output logic [ALU:0]                   entryRelease,
   output logic [15:0]                    issueCount,
   output logic [15:0]                    stallCount
);

   localparam int N  = ALU + 1;
   localparam int TW = ROB + 1;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   ptr_q,   ptr_d;
   logic [N-1:0]    oh_q,    oh_d;
   logic [IW-1:0]   idx_q,   idx_d;
   logic [TW-1:0]   rob_q,   rob_d;

   logic            held_busy;
   logic            handshake;
   logic [N-1:0]    eligible;
   logic            any_elig;
   logic [IW-1:0]   start_ptr;
   logic [IW-1:0]   pick_idx;
   logic [N-1:0]    pick_oh;
   logic [TW-1:0]   pick_rob;

   // Index one past idx, wrapping from the last entry back to 0.
   function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] idx);
      if (int'(idx) >= N - 1) begin
         return '0;
      end
      return idx + IW'(1);
   endfunction

   // First set bit of elig, searching upward from start with wrap-around.
   function automatic logic [IW-1:0] rr_index(input logic [N-1:0]  elig,
                                              input logic [IW-1:0] start);
      logic [IW-1:0] pick;
      logic          hit;
      int            pos;
      pick = '0;
      hit  = 1'b0;
      for (int k = 0; k < N; k++) begin
         pos = (int'(start) + k) % N;
         if (!hit && elig[pos]) begin
            pick = IW'(pos);
            hit  = 1'b1;
         end
      end
      return pick;
   endfunction

   assign issueValid  = (state_q == HOLD);
   assign issueOneHot = oh_q;
   assign issueIndex  = idx_q;
   assign issueRob    = rob_q;

   // A held entry whose busy bit has fallen is no longer issuable. Reset is
   // folded in so that no release pulse can leak out during the reset cycle.
   assign held_busy = |(entryBusy & oh_q);
   assign handshake = issueValid & fuReady & ~flush & held_busy & ~reset;

   assign entryRelease = handshake ? oh_q : '0;

   // The entry currently presented must not be re-picked on its own
   // handshake cycle, so it is masked out while holding.
   assign eligible = entryBusy & entryReady & ~(issueValid ? oh_q : '0);
   assign any_elig = |eligible;

   // On a handshake the back-to-back pick already searches from the updated
   // pointer, so the next entry appears without an idle bubble.
   assign start_ptr = handshake ? next_ptr(idx_q) : ptr_q;
   assign pick_idx  = rr_index(eligible, start_ptr);
   assign pick_rob  = entryRob[int'(pick_idx)*TW +: TW];

   always_comb begin
      pick_oh           = '0;
      pick_oh[pick_idx] = 1'b1;
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      oh_d    = oh_q;
      idx_d   = idx_q;
      rob_d   = rob_q;

      if (flush) begin
         // Redirect wins over everything: drop the presentation, keep ptr.
         state_d = IDLE;
         oh_d    = '0;
         idx_d   = '0;
         rob_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (any_elig) begin
                  state_d = HOLD;
                  oh_d    = pick_oh;
                  idx_d   = pick_idx;
                  rob_d   = pick_rob;
               end
            end
            HOLD: begin
               if (!held_busy) begin
                  state_d = IDLE;
                  oh_d    = '0;
                  idx_d   = '0;
                  rob_d   = '0;
               end else if (handshake) begin
                  ptr_d = next_ptr(idx_q);
                  if (any_elig) begin
                     state_d = HOLD;
                     oh_d    = pick_oh;
                     idx_d   = pick_idx;
                     rob_d   = pick_rob;
                  end else begin
                     state_d = IDLE;
                     oh_d    = '0;
                     idx_d   = '0;
                     rob_d   = '0;
                  end
               end
            end
            default: begin
               state_d = IDLE;
               oh_d    = '0;
               idx_d   = '0;
               rob_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         oh_q    <= '0;
         idx_q   <= '0;
         rob_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         oh_q    <= oh_d;
         idx_q   <= idx_d;
         rob_q   <= rob_d;
      end
   end

`ifdef RS_ISSUE_PERF_EN
   logic [15:0] issue_cnt_q, issue_cnt_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;

   // Both counters stick at all-ones instead of wrapping.
   always_comb begin
      issue_cnt_d = issue_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (handshake && (issue_cnt_q != 16'hFFFF)) begin
         issue_cnt_d = issue_cnt_q + 16'd1;
      end
      if (issueValid && !fuReady && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         issue_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         issue_cnt_q <= issue_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign issueCount = issue_cnt_q;
   assign stallCount = stall_cnt_q;
`else
   assign issueCount = 16'd0;
   assign stallCount = 16'd0;
`endif

   // Structural invariants of the presentation registers.
   a_onehot: assert property (@(posedge clk) disable iff (reset)
                              $onehot0(issueOneHot));
   a_idle_zero: assert property (@(posedge clk) disable iff (reset)
                                 !issueValid |-> (issueOneHot == '0));

endmodule
